// File: rtl/spmv_val_rd_arbiter_if.sv
// rtl/spmv_val_rd_arbiter_if.sv - kernel-side and HBM-side AXI read channels of the Val read arbiter
interface spmv_val_rd_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 256
);
    // kernel-side (merged) read masters
    logic [NUM_PORTS*ADDR_W-1:0] s_axi_araddr;
    logic [NUM_PORTS*8-1:0]      s_axi_arlen;
    logic [NUM_PORTS*3-1:0]      s_axi_arsize;
    logic [NUM_PORTS*2-1:0]      s_axi_arburst;
    logic [NUM_PORTS-1:0]        s_axi_arvalid;
    logic [NUM_PORTS-1:0]        s_axi_arready;
    logic [NUM_PORTS*DATA_W-1:0] s_axi_rdata;
    logic [NUM_PORTS*2-1:0]      s_axi_rresp;
    logic [NUM_PORTS-1:0]        s_axi_rlast;
    logic [NUM_PORTS-1:0]        s_axi_rvalid;
    logic [NUM_PORTS-1:0]        s_axi_rready;

    // HBM pseudo-channel
    logic [ADDR_W-1:0]           m_axi_araddr;
    logic [7:0]                  m_axi_arlen;
    logic [2:0]                  m_axi_arsize;
    logic [1:0]                  m_axi_arburst;
    logic                        m_axi_arvalid;
    logic                        m_axi_arready;
    logic [DATA_W-1:0]           m_axi_rdata;
    logic [1:0]                  m_axi_rresp;
    logic                        m_axi_rlast;
    logic                        m_axi_rvalid;
    logic                        m_axi_rready;

    // arbiter's view: serves the kernels, drives the HBM port
    modport slave (
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_arready,
        output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        input  m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        output m_axi_rready
    );

    // environment's view: kernels plus HBM model
    modport master (
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_arready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
        output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
        input  m_axi_rready
    );
endinterface

// File: rtl/spmv_val_rd_arbiter.sv
// rtl/spmv_val_rd_arbiter.sv - round-robin N-to-1 AXI read arbiter for SpMV Val streams (optional perf counters: SPMV_VAL_ARB_PERF_EN)
module spmv_val_rd_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 48,
    parameter int DATA_W    = 256,
    parameter int MAX_OUTST = 16
) (
    input  logic clk,
    input  logic rstn,
    spmv_val_rd_arbiter_if.slave bus
`ifdef SPMV_VAL_ARB_PERF_EN
    ,
    output logic [NUM_PORTS*32-1:0] perf_burst_cnt
`endif
);
    localparam int GW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(MAX_OUTST);
    localparam int PW = AW + 1;

    logic [GW-1:0]     last_grant;
    logic [GW-1:0]     grant;
    logic              grant_valid;
    logic              load;
    logic              accept;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [GW-1:0]     fifo_mem [MAX_OUTST];
    logic [GW-1:0]     head;

    logic [ADDR_W-1:0] ar_addr;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              ar_valid;

    // Grant FIFO status: extra wrap bit tells full from empty when indices match
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = fifo_mem[rd_ptr[AW-1:0]];

    // Output slice may reload when empty or draining; rstn gating keeps arready low in reset
    assign load   = rstn && (!ar_valid || bus.m_axi_arready) && !fifo_full;
    assign accept = load && grant_valid;

    // Round-robin search from last_grant+1; scanning far-to-near lets the nearest requester win
    always_comb begin : grant_search
        int idx;
        idx         = 0;
        grant       = last_grant;
        grant_valid = 1'b0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (bus.s_axi_arvalid[idx]) begin
                grant       = GW'(idx);
                grant_valid = 1'b1;
            end
        end
    end

    // One-hot AR ready to the granted kernel
    always_comb begin
        bus.s_axi_arready = '0;
        if (accept) begin
            bus.s_axi_arready[grant] = 1'b1;
        end
    end

    // Registered AR slice towards HBM; fields hold while the beat waits for arready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ar_addr    <= '0;
            ar_len     <= '0;
            ar_size    <= '0;
            ar_burst   <= '0;
            ar_valid   <= 1'b0;
            last_grant <= GW'(NUM_PORTS - 1);
        end else if (accept) begin
            ar_addr    <= bus.s_axi_araddr[int'(grant)*ADDR_W +: ADDR_W];
            ar_len     <= bus.s_axi_arlen[int'(grant)*8 +: 8];
            ar_size    <= bus.s_axi_arsize[int'(grant)*3 +: 3];
            ar_burst   <= bus.s_axi_arburst[int'(grant)*2 +: 2];
            ar_valid   <= 1'b1;
            last_grant <= grant;
        end else if (bus.m_axi_arready) begin
            ar_valid   <= 1'b0;
        end
    end

    assign bus.m_axi_araddr  = ar_addr;
    assign bus.m_axi_arlen   = ar_len;
    assign bus.m_axi_arsize  = ar_size;
    assign bus.m_axi_arburst = ar_burst;
    assign bus.m_axi_arvalid = ar_valid;

    // Grant FIFO pointers: push on accepted AR, pop on the last R beat of the head burst
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Grant FIFO storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_mem[wr_ptr[AW-1:0]] <= grant;
        end
    end

    // R routing: data broadcast, valid steered to the burst owner; stray beats stall when empty
    assign bus.s_axi_rdata  = {NUM_PORTS{bus.m_axi_rdata}};
    assign bus.s_axi_rresp  = {NUM_PORTS{bus.m_axi_rresp}};
    assign bus.s_axi_rlast  = {NUM_PORTS{bus.m_axi_rlast}};
    assign bus.m_axi_rready = bus.s_axi_rready[head] && !fifo_empty;
    assign pop              = bus.m_axi_rvalid && bus.m_axi_rready && bus.m_axi_rlast;

    // One-hot R valid to the FIFO head owner
    always_comb begin
        bus.s_axi_rvalid = '0;
        if (bus.m_axi_rvalid && !fifo_empty) begin
            bus.s_axi_rvalid[head] = 1'b1;
        end
    end

`ifdef SPMV_VAL_ARB_PERF_EN
    logic [31:0] perf_cnt [NUM_PORTS];

    // Per-kernel accepted-burst counters, wrap modulo 2^32
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                perf_cnt[i] <= '0;
            end
        end else if (accept) begin
            perf_cnt[grant] <= perf_cnt[grant] + 32'd1;
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_perf
        assign perf_burst_cnt[i*32 +: 32] = perf_cnt[i];
    end
`endif

endmodule

// File: tb/tb_spmv_val_rd_arbiter.sv
// tb/tb_spmv_val_rd_arbiter.sv - self-checking bench for spmv_val_rd_arbiter
module tb_spmv_val_rd_arbiter;
    localparam int NP = 4;
    localparam int AW = 48;
    localparam int DW = 256;
    localparam int MO = 16;

    logic clk = 1'b0;
    logic rstn;
    int   total = 0;
    int   bad   = 0;

    spmv_val_rd_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef SPMV_VAL_ARB_PERF_EN
    logic [NP*32-1:0] perf_burst_cnt;
`endif

    spmv_val_rd_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
`ifdef SPMV_VAL_ARB_PERF_EN
        ,
        .perf_burst_cnt (perf_burst_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NP-1:0] arvalid;
        logic          m_arready;
        logic [NP-1:0] exp_arready;
        logic          exp_mvalid;
        int            exp_port;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [AW-1:0] addr_of(input int p);
        return 48'h1234_0000_0000 + 48'(p + 1) * 48'h40;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // fixed_len < 0 gives port i an arlen of i
    task automatic set_ports(input int fixed_len);
        for (int i = 0; i < NP; i++) begin
            bus.s_axi_araddr[i*AW +: AW] = addr_of(i);
            bus.s_axi_arlen[i*8 +: 8]    = (fixed_len < 0) ? 8'(i) : 8'(fixed_len);
            bus.s_axi_arsize[i*3 +: 3]   = 3'd5;
            bus.s_axi_arburst[i*2 +: 2]  = 2'd1;
        end
    endtask

    task automatic do_reset(input bit check);
        rstn              = 1'b0;
        bus.s_axi_arvalid = '1;
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rvalid  = 1'b1;
        bus.m_axi_rlast   = 1'b1;
        bus.s_axi_rready  = '1;
        tick();
        tick();
        if (check) begin
            chk("reset_s_arready", 64'(bus.s_axi_arready), 64'h0);
            chk("reset_m_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
            chk("reset_m_rready",  64'(bus.m_axi_rready),  64'h0);
            chk("reset_s_rvalid",  64'(bus.s_axi_rvalid),  64'h0);
            chk("reset_m_araddr",  64'(bus.m_axi_araddr),  64'h0);
        end
        bus.s_axi_arvalid = '0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.s_axi_rready  = '0;
        rstn              = 1'b1;
    endtask

    initial begin
        int got;
        int beat;
        int stalls;
        logic exp_rr;

        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 1};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 3};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 0};
        vecs[5]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 0};
        vecs[6]  = '{4'b1010, 1'b0, 4'b0000, 1'b1, 0};
        vecs[7]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 1};
        vecs[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, -1};
        vecs[9]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 3};
        vecs[10] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 3};
        vecs[11] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 0};

        bus.m_axi_rdata = '0;
        bus.m_axi_rresp = 2'd0;
        set_ports(-1);
        #2;
        do_reset(1'b1);

        // round-robin and output-slice hold/clear
        for (int v = 0; v < 12; v++) begin
            bus.s_axi_arvalid = vecs[v].arvalid;
            bus.m_axi_arready = vecs[v].m_arready;
            #1;
            chk($sformatf("rr%0d_arready", v), 64'(bus.s_axi_arready), 64'(vecs[v].exp_arready));
            tick();
            chk($sformatf("rr%0d_m_arvalid", v), 64'(bus.m_axi_arvalid), 64'(vecs[v].exp_mvalid));
            if (vecs[v].exp_port >= 0) begin
                chk($sformatf("rr%0d_m_araddr", v), 64'(bus.m_axi_araddr), 64'(addr_of(vecs[v].exp_port)));
                chk($sformatf("rr%0d_m_arlen", v), 64'(bus.m_axi_arlen), 64'(vecs[v].exp_port));
            end
        end

        // return routing: port 2 then port 0, four beats each
        do_reset(1'b0);
        set_ports(3);
        bus.m_axi_arready = 1'b1;
        bus.s_axi_arvalid = 4'b0100;
        #1;
        chk("ret_grant2", 64'(bus.s_axi_arready), 64'h4);
        tick();
        bus.s_axi_arvalid = 4'b0001;
        #1;
        chk("ret_grant0", 64'(bus.s_axi_arready), 64'h1);
        tick();
        bus.s_axi_arvalid = '0;
        bus.s_axi_rready  = '1;
        for (int b = 0; b < 8; b++) begin
            bus.m_axi_rvalid = 1'b1;
            bus.m_axi_rdata  = {4{64'(100 + b)}};
            bus.m_axi_rlast  = (b == 3) || (b == 7);
            #1;
            chk($sformatf("ret_b%0d_rvalid", b), 64'(bus.s_axi_rvalid), (b < 4) ? 64'h4 : 64'h1);
            chk($sformatf("ret_b%0d_m_rready", b), 64'(bus.m_axi_rready), 64'h1);
            chk($sformatf("ret_b%0d_data", b),
                (b < 4) ? bus.s_axi_rdata[2*DW +: 64] : bus.s_axi_rdata[0 +: 64], 64'(100 + b));
            tick();
        end
        bus.m_axi_rlast = 1'b0;
        #1;
        chk("ret_empty_rvalid", 64'(bus.s_axi_rvalid), 64'h0);
        chk("ret_empty_m_rready", 64'(bus.m_axi_rready), 64'h0);
        bus.m_axi_rvalid = 1'b0;
        tick();

        // back-pressure: port 1 burst of 8 beats, kernel stalls 5 cycles after beat 2
        do_reset(1'b0);
        set_ports(7);
        bus.m_axi_arready = 1'b1;
        bus.s_axi_arvalid = 4'b0010;
        tick();
        bus.s_axi_arvalid = '0;
        got    = 0;
        beat   = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            bus.s_axi_rready = (cyc >= 3 && cyc < 8) ? 4'b0000 : 4'b0010;
            bus.m_axi_rvalid = (beat < 8);
            bus.m_axi_rdata  = {4{64'(200 + beat)}};
            bus.m_axi_rlast  = (beat == 7);
            exp_rr           = !(cyc >= 3 && cyc < 8);
            #1;
            chk($sformatf("bp_c%0d_m_rready", cyc), 64'(bus.m_axi_rready), 64'(exp_rr));
            if (!bus.m_axi_rready) stalls++;
            if (bus.s_axi_rvalid[1] && bus.s_axi_rready[1]) begin
                chk($sformatf("bp_beat%0d_data", got), bus.s_axi_rdata[1*DW +: 64], 64'(200 + got));
                got++;
            end
            if (bus.m_axi_rvalid && bus.m_axi_rready) beat++;
            tick();
        end
        chk("bp_beats_received", 64'(got), 64'd8);
        chk("bp_stall_cycles", 64'(stalls), 64'd5);
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.s_axi_rready = '0;

        // full: 16 outstanding bursts, 17th waits until the first rlast pops
        do_reset(1'b0);
        set_ports(0);
        bus.m_axi_arready = 1'b1;
        bus.s_axi_arvalid = 4'b0001;
        for (int n = 0; n < MO; n++) begin
            #1;
            chk($sformatf("full_acc%0d", n), 64'(bus.s_axi_arready), 64'h1);
            tick();
        end
        for (int n = 0; n < 3; n++) begin
            #1;
            chk($sformatf("full_block%0d", n), 64'(bus.s_axi_arready), 64'h0);
            tick();
        end
        bus.m_axi_rvalid = 1'b1;
        bus.m_axi_rlast  = 1'b1;
        bus.s_axi_rready = 4'b0001;
        #1;
        chk("full_pop_cycle_arready", 64'(bus.s_axi_arready), 64'h0);
        chk("full_pop_cycle_m_rready", 64'(bus.m_axi_rready), 64'h1);
        tick();
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        #1;
        chk("full_after_pop_arready", 64'(bus.s_axi_arready), 64'h1);
        tick();
        bus.s_axi_arvalid = '0;

`ifdef SPMV_VAL_ARB_PERF_EN
        // perf: 10 bursts from port 1, 3 from port 3
        do_reset(1'b0);
        bus.m_axi_arready = 1'b1;
        bus.s_axi_arvalid = 4'b0010;
        for (int n = 0; n < 10; n++) tick();
        bus.s_axi_arvalid = 4'b1000;
        for (int n = 0; n < 3; n++) tick();
        bus.s_axi_arvalid = '0;
        tick();
        chk("perf0", 64'(perf_burst_cnt[0*32 +: 32]), 64'd0);
        chk("perf1", 64'(perf_burst_cnt[1*32 +: 32]), 64'd10);
        chk("perf2", 64'(perf_burst_cnt[2*32 +: 32]), 64'd0);
        chk("perf3", 64'(perf_burst_cnt[3*32 +: 32]), 64'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
